// File: rtl/decode_format_arbiter_if.sv
// rtl/decode_format_arbiter_if.sv - decoder-lane and backend handshake bundle for the format arbiter
interface decode_format_arbiter_if #(
  parameter int NUM_DEC   = 4,
  parameter int PAYLOAD_W = 128,
  parameter int MAJ_ID_W  = 64,
  parameter int MIN_ID_W  = 7
);
  localparam int SRC_W = $clog2(NUM_DEC);

  logic [NUM_DEC-1:0]           dec_enable_i;
  logic [NUM_DEC*PAYLOAD_W-1:0] dec_payload_i;
  logic [NUM_DEC*MAJ_ID_W-1:0]  dec_majId_i;
  logic [NUM_DEC*MIN_ID_W-1:0]  dec_minId_i;
  logic [NUM_DEC-1:0]           dec_stall_o;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic [PAYLOAD_W-1:0]         out_payload_o;
  logic [MAJ_ID_W-1:0]          out_majId_o;
  logic [MIN_ID_W-1:0]          out_minId_o;
  logic [SRC_W-1:0]             out_src_o;
  logic                         overflow_o;

  modport master (
    output dec_enable_i, dec_payload_i, dec_majId_i, dec_minId_i, out_ready_i,
    input  dec_stall_o, out_valid_o, out_payload_o, out_majId_o, out_minId_o,
           out_src_o, overflow_o
  );

  modport slave (
    input  dec_enable_i, dec_payload_i, dec_majId_i, dec_minId_i, out_ready_i,
    output dec_stall_o, out_valid_o, out_payload_o, out_majId_o, out_minId_o,
           out_src_o, overflow_o
  );
endinterface

// File: rtl/decode_format_arbiter.sv
// rtl/decode_format_arbiter.sv - per-lane FIFOs merged oldest-first into one registered in-order stream
module decode_format_arbiter #(
  parameter int NUM_DEC    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int PAYLOAD_W  = 128,
  parameter int MAJ_ID_W   = 64,
  parameter int MIN_ID_W   = 7
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  decode_format_arbiter_if.slave bus
);
  localparam int SRC_W = $clog2(NUM_DEC);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int KEY_W = MAJ_ID_W + MIN_ID_W;

  logic [PAYLOAD_W-1:0] r_pay [NUM_DEC][FIFO_DEPTH];
  logic [MAJ_ID_W-1:0]  r_maj [NUM_DEC][FIFO_DEPTH];
  logic [MIN_ID_W-1:0]  r_min [NUM_DEC][FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wptr [NUM_DEC];
  logic [PTR_W-1:0]     r_rptr [NUM_DEC];
  logic [CNT_W-1:0]     r_cnt  [NUM_DEC];

  logic                 r_out_valid;
  logic [PAYLOAD_W-1:0] r_out_pay;
  logic [MAJ_ID_W-1:0]  r_out_maj;
  logic [MIN_ID_W-1:0]  r_out_min;
  logic [SRC_W-1:0]     r_out_src;
  logic                 r_ovf;

  logic [NUM_DEC-1:0]   w_stall;
  logic [NUM_DEC-1:0]   w_push;
  logic [NUM_DEC-1:0]   w_pop;
  logic [NUM_DEC-1:0]   w_cand;
  logic [KEY_W-1:0]     w_key [NUM_DEC];
  logic [KEY_W-1:0]     w_best;
  logic [SRC_W-1:0]     w_win;
  logic                 w_any;
  logic                 w_free;
  logic                 w_load;

  always_comb begin
    for (int i = 0; i < NUM_DEC; i++) begin
      w_stall[i] = (r_cnt[i] == CNT_W'(FIFO_DEPTH));
      w_cand[i]  = (r_cnt[i] != '0);
      w_push[i]  = bus.dec_enable_i[i] && !w_stall[i];
      w_key[i]   = {r_maj[i][r_rptr[i]], r_min[i][r_rptr[i]]};
    end
  end

  // Strict less-than keeps the lowest lane on equal keys.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_best = '0;
    for (int i = 0; i < NUM_DEC; i++) begin
      if (w_cand[i] && (!w_any || (w_key[i] < w_best))) begin
        w_any  = 1'b1;
        w_win  = SRC_W'(i);
        w_best = w_key[i];
      end
    end
  end

  assign w_free = !r_out_valid || bus.out_ready_i;
  assign w_load = w_free && w_any;

  always_comb begin
    for (int i = 0; i < NUM_DEC; i++) begin
      w_pop[i] = w_load && (w_win == SRC_W'(i));
    end
  end

  always_ff @(posedge clock_i) begin
    for (int i = 0; i < NUM_DEC; i++) begin
      if (w_push[i]) begin
        r_pay[i][r_wptr[i]] <= bus.dec_payload_i[i*PAYLOAD_W +: PAYLOAD_W];
        r_maj[i][r_wptr[i]] <= bus.dec_majId_i[i*MAJ_ID_W +: MAJ_ID_W];
        r_min[i][r_wptr[i]] <= bus.dec_minId_i[i*MIN_ID_W +: MIN_ID_W];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_DEC; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_out_valid <= 1'b0;
      r_out_pay   <= '0;
      r_out_maj   <= '0;
      r_out_min   <= '0;
      r_out_src   <= '0;
      r_ovf       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DEC; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + PTR_W'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PTR_W'(1);
        r_cnt[i] <= r_cnt[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
      end
      if (|(bus.dec_enable_i & w_stall)) r_ovf <= 1'b1;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_pay   <= r_pay[w_win][r_rptr[w_win]];
        r_out_maj   <= r_maj[w_win][r_rptr[w_win]];
        r_out_min   <= r_min[w_win][r_rptr[w_win]];
        r_out_src   <= w_win;
      end else if (w_free) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.dec_stall_o   = w_stall;
  assign bus.out_valid_o   = r_out_valid;
  assign bus.out_payload_o = r_out_pay;
  assign bus.out_majId_o   = r_out_maj;
  assign bus.out_minId_o   = r_out_min;
  assign bus.out_src_o     = r_out_src;
  assign bus.overflow_o    = r_ovf;
endmodule
